// File: rtl/int2float_pipe.sv
// Pipelined integer-to-minifloat converter: stage 1 takes the magnitude and finds its
// leading one, stage 2 encodes, rounds and saturates. Valid/ready with full backpressure.
module int2float_pipe #(
    parameter int IN_W   = 11,
    parameter int EXP_W  = 3,
    parameter int MAN_W  = 4,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [IN_W-1:0]                 in_data,
    input  logic                            rnd_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SIGNED+EXP_W+MAN_W-1:0]   out_data,
    output logic                            out_ovf,
    output logic [CNT_W-1:0]                sat_cnt,
    input  logic                            sat_clr
);
    localparam int OUT_W = SIGNED + EXP_W + MAN_W;
    localparam int P_W   = $clog2(IN_W);
    localparam int E_RAW = $clog2(IN_W + 2) + 1;
    // Internal exponent is wide enough to hold the largest unsaturated-overflow exponent.
    localparam int E_W   = (E_RAW > EXP_W + 1) ? E_RAW : EXP_W + 1;
    localparam bit IS_SGN = (SIGNED != 32'sd0);

    localparam logic [IN_W-1:0]  ONE_IN   = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [IN_W-1:0]  ALL_ONES = {IN_W{1'b1}};
    localparam logic [P_W-1:0]   ONE_P    = {{(P_W-1){1'b0}}, 1'b1};
    localparam logic [P_W-1:0]   P_MAN    = P_W'(MAN_W);
    localparam logic [MAN_W:0]   ONE_M    = {{MAN_W{1'b0}}, 1'b1};
    localparam logic [E_W-1:0]   EXP_BIAS = E_W'(MAN_W - 1);
    localparam logic [E_W-1:0]   EXP_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [P_W-1:0] lead_one(input logic [IN_W-1:0] v);
        logic [P_W-1:0] idx;
        idx = {P_W{1'b0}};
        for (int i = 0; i < IN_W; i++) begin
            idx = v[i] ? P_W'(i) : idx;
        end
        return idx;
    endfunction

    logic                neg_s;
    logic [IN_W-1:0]     mag_s;
    logic [P_W-1:0]      msb_s;
    logic                s1_valid_r;
    logic [IN_W-1:0]     s1_mag_r;
    logic [P_W-1:0]      s1_msb_r;
    logic                s1_rnd_r;
    logic                out_free_s;
    logic [P_W-1:0]      sh_s;
    logic [IN_W-1:0]     rem_s;
    logic [IN_W-1:0]     half_s;
    logic [MAN_W-1:0]    man_s;
    logic [MAN_W:0]      man_inc_s;
    logic [E_W-1:0]      exp_s;
    logic                rnd_up_s;
    logic                ovf_s;
    logic [EXP_W-1:0]    exp_fld_s;
    logic [MAN_W-1:0]    man_fld_s;
    logic [OUT_W-1:0]    res_s;
    logic                out_valid_r;
    logic [OUT_W-1:0]    out_data_r;
    logic                out_ovf_r;
    logic [CNT_W-1:0]    sat_cnt_r;

    assign out_free_s = ~out_valid_r | out_ready;
    assign in_ready   = ~s1_valid_r | out_free_s;

    // Stage 1 combinational: absolute value and leading-one position.
    always_comb begin
        neg_s = 1'b0;
        mag_s = in_data;
        if (IS_SGN && in_data[IN_W-1]) begin
            neg_s = 1'b1;
            mag_s = (~in_data) + ONE_IN;
        end else begin
            neg_s = 1'b0;
            mag_s = in_data;
        end
        msb_s = lead_one(mag_s);
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_mag_r   <= {IN_W{1'b0}};
            s1_msb_r   <= {P_W{1'b0}};
            s1_rnd_r   <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mag_r <= mag_s;
                s1_msb_r <= msb_s;
                s1_rnd_r <= rnd_mode;
            end
        end
    end

    // Stage 2 combinational: normalise, extract remainder, apply round-to-nearest-even.
    always_comb begin
        sh_s      = {P_W{1'b0}};
        rem_s     = {IN_W{1'b0}};
        half_s    = {IN_W{1'b0}};
        man_s     = s1_mag_r[MAN_W-1:0];
        man_inc_s = {(MAN_W+1){1'b0}};
        exp_s     = {E_W{1'b0}};
        rnd_up_s  = 1'b0;
        if (~|s1_mag_r[IN_W-1:MAN_W]) begin
            man_s = s1_mag_r[MAN_W-1:0];
            exp_s = {E_W{1'b0}};
        end else begin
            sh_s      = s1_msb_r - P_MAN;
            man_s     = MAN_W'(s1_mag_r >> sh_s);
            rem_s     = s1_mag_r & ~(ALL_ONES << sh_s);
            // With no remainder bits there is nothing to round.
            half_s    = (sh_s == {P_W{1'b0}}) ? {IN_W{1'b0}} : (ONE_IN << (sh_s - ONE_P));
            rnd_up_s  = s1_rnd_r && (sh_s != {P_W{1'b0}}) &&
                        ((rem_s > half_s) || ((rem_s == half_s) && man_s[0]));
            man_inc_s = {1'b0, man_s} + ONE_M;
            exp_s     = E_W'(s1_msb_r) - EXP_BIAS +
                        (rnd_up_s ? E_W'(man_inc_s[MAN_W]) : {E_W{1'b0}});
            man_s     = rnd_up_s ? man_inc_s[MAN_W-1:0] : man_s;
        end
    end

    assign ovf_s     = (exp_s > EXP_MAX);
    assign exp_fld_s = ovf_s ? {EXP_W{1'b1}} : exp_s[EXP_W-1:0];
    assign man_fld_s = ovf_s ? {MAN_W{1'b1}} : man_s;

    generate
        if (IS_SGN) begin : g_sign
            logic s1_sign_r;
            // Sign travels alongside the magnitude through stage 1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_sign_r <= 1'b0;
                end else if (in_ready && in_valid) begin
                    s1_sign_r <= neg_s;
                end
            end
            assign res_s = {s1_sign_r, exp_fld_s, man_fld_s};
        end else begin : g_nosign
            assign res_s = {exp_fld_s, man_fld_s};
        end
    endgenerate

    // Output stage: holds the result while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_ovf_r   <= 1'b0;
        end else if (out_free_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_data_r <= res_s;
                out_ovf_r  <= ovf_s;
            end
        end
    end

    // Saturated-result counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_r <= {CNT_W{1'b0}};
        end else if (sat_clr) begin
            sat_cnt_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && out_ready && out_ovf_r && !(&sat_cnt_r)) begin
            sat_cnt_r <= sat_cnt_r + CNT_ONE;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign sat_cnt   = sat_cnt_r;

endmodule
